// File: rtl/uart_pkg.sv
// Shared types and constants for the debug UART. The TX path imports this package as well.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } rx_state_e;

    // Integer clocks per bit period. Any remainder is dropped.
    function automatic int clks_per_bit(input int clk_rate, input int baud_rate);
        return clk_rate / baud_rate;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Pull interface between the receive FIFO and the TAP packet parser.
interface uart_rx_if;
    import uart_pkg::*;

    logic                 re;
    logic [DATA_BITS-1:0] dout;
    logic                 rx_empty;
    logic                 rx_full;
    logic                 frame_err;
    logic                 overflow;
    logic                 err_clr;

    // Consumer side (the TAP parser).
    modport master (
        output re, err_clr,
        input  dout, rx_empty, rx_full, frame_err, overflow
    );

    // Producer side (the UART receiver).
    modport slave (
        input  re, err_clr,
        output dout, rx_empty, rx_full, frame_err, overflow
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO with a registered output. A push into a full FIFO is
// accepted only when a pop frees a slot in the same cycle. A pop from an empty
// FIFO is ignored. Storage is not reset; the pointers and count define the contents.
module uart_rx_fifo #(
    parameter int FIFO_DEPTH = 8,
    parameter int WIDTH      = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic                          pop,
    input  logic [WIDTH-1:0]              din,
    output logic [WIDTH-1:0]              dout,
    output logic [$clog2(FIFO_DEPTH):0]   count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    if (FIFO_DEPTH < 2 || (1 << AW) != FIFO_DEPTH) begin : g_depth_chk
        $error("uart_rx_fifo: FIFO_DEPTH must be a power of two >= 2");
    end

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             pop_ok, push_ok;

    // The empty and full decisions use the count from before this cycle.
    assign pop_ok  = pop && (count != '0);
    assign push_ok = push && ((count != CW'(FIFO_DEPTH)) || pop_ok);

    // Storage write.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

    // Pointers, occupancy count, and the registered head output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            dout   <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
                dout   <= mem[rd_ptr];
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/uart_rx.sv
// 8N1 receiver with a 2-flop synchronizer, a mid-bit sampling FSM, a receive FIFO,
// and sticky framing-error and overflow flags.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_RATE   = 100000000,
    parameter int BAUD_RATE  = 3000000,
    parameter int FIFO_DEPTH = 8
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      rx_i,
    uart_rx_if.slave  bus
);
    localparam int CPB = clks_per_bit(CLK_RATE, BAUD_RATE);
    localparam int CW  = $clog2(CPB) + 1;
    localparam logic [CW-1:0] HALF_LAST = CW'(CPB / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CPB - 1);

    if (CPB < 4) begin : g_cpb_chk
        $error("uart_rx: CLK_RATE / BAUD_RATE must be >= 4");
    end

    logic                        rx_meta, rx_s;
    rx_state_e                   state, state_n;
    logic [CW-1:0]               cnt, cnt_n;
    logic [2:0]                  idx, idx_n;
    logic [DATA_BITS-1:0]        shreg, shreg_n;
    logic                        push_set, ferr_set;
    logic                        push_q;
    logic [$clog2(FIFO_DEPTH):0] count;
    logic                        full;

    // Two-flop synchronizer. The flops reset to the idle line level.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rx_s    <= rx_meta;
        end
    end

    // FSM state, bit timing, and shift register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            idx    <= '0;
            shreg  <= '0;
            push_q <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            idx    <= idx_n;
            shreg  <= shreg_n;
            push_q <= push_set;
        end
    end

    // Next-state logic. The start bit is checked at half a bit period; data and stop
    // bits are sampled one full period after the previous sample, near the bit centre.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt + CW'(1);
        idx_n    = idx;
        shreg_n  = shreg;
        push_set = 1'b0;
        ferr_set = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_n = '0;
                if (!rx_s) state_n = ST_START;
            end
            ST_START: begin
                if (cnt == HALF_LAST) begin
                    cnt_n = '0;
                    if (!rx_s) begin
                        state_n = ST_DATA;
                        idx_n   = '0;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_n          = '0;
                    shreg_n[idx]   = rx_s;
                    if (idx == 3'(DATA_BITS - 1)) state_n = ST_STOP;
                    else                          idx_n   = idx + 3'd1;
                end
            end
            ST_STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        push_set = 1'b1;
                        state_n  = ST_IDLE;
                    end else begin
                        ferr_set = 1'b1;
                        state_n  = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                cnt_n = '0;
                if (rx_s) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    uart_rx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      (DATA_BITS)
    ) u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (push_q),
        .pop   (bus.re),
        .din   (shreg),
        .dout  (bus.dout),
        .count (count)
    );

    assign full         = (count == ($clog2(FIFO_DEPTH) + 1)'(FIFO_DEPTH));
    assign bus.rx_empty = (count == '0);
    assign bus.rx_full  = full;

    // Sticky error flags. A set in the same cycle as a clear wins.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bus.frame_err <= 1'b0;
            bus.overflow  <= 1'b0;
        end else begin
            if (ferr_set)         bus.frame_err <= 1'b1;
            else if (bus.err_clr) bus.frame_err <= 1'b0;
            if (push_q && full && !bus.re) bus.overflow <= 1'b1;
            else if (bus.err_clr)          bus.overflow <= 1'b0;
        end
    end
endmodule
